// File: rtl/wb_copy_pkg.sv
// Shared types and constants for the Wishbone word-copy engine.
// Register offsets are word indices taken from wbs_adr_i[3:2].
package wb_copy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_GAP,
        WR,
        WR_GAP,
        FIN
    } state_t;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_IE    = 3;
    localparam int CTRL_ERR   = 4;
    localparam int CTRL_ABORT = 5;

    function automatic logic is_busy(input state_t s);
        return (s == RD) || (s == RD_GAP) || (s == WR) || (s == WR_GAP);
    endfunction

endpackage

// File: rtl/wb_copy_regs.sv
// Slave-side decode, registered ack/read data and CTRL/STAT bits.
// SRC/DST/LEN live in the top as counters; this block only produces their write strobes.
module wb_copy_regs
    import wb_copy_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_cyc,
    input  logic             wb_stb,
    input  logic             wb_we,
    input  logic [1:0]       wb_adr,
    input  logic [5:0]       ctrl_wdata,
    output logic [31:0]      wb_rdata,
    output logic             wb_ack,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic             busy,
    input  logic             set_done,
    input  logic             set_err,
    input  logic             clr_stat,
    output logic             wr_src,
    output logic             wr_dst,
    output logic             wr_len,
    output logic             start,
    output logic             abort,
    output logic             done,
    output logic             err,
    output logic             ie
);

    logic        access;
    logic        wr_en;
    logic        wr_ctrl;
    logic [31:0] rd_mux;

    assign access  = wb_cyc & wb_stb & ~wb_ack;
    assign wr_en   = access & wb_we;
    assign wr_src  = wr_en & (wb_adr == REG_SRC);
    assign wr_dst  = wr_en & (wb_adr == REG_DST);
    assign wr_len  = wr_en & (wb_adr == REG_LEN);
    assign wr_ctrl = wr_en & (wb_adr == REG_CTRL);
    assign start   = wr_ctrl & ctrl_wdata[CTRL_START];
    assign abort   = wr_ctrl & ctrl_wdata[CTRL_ABORT];

    always_comb begin
        rd_mux = '0;
        case (wb_adr)
            REG_SRC: rd_mux = src;
            REG_DST: rd_mux = dst;
            REG_LEN: rd_mux = {{(32-LEN_W){1'b0}}, len};
            default: begin
                rd_mux[CTRL_BUSY] = busy;
                rd_mux[CTRL_DONE] = done;
                rd_mux[CTRL_IE]   = ie;
                rd_mux[CTRL_ERR]  = err;
            end
        endcase
    end

    // Hardware set beats a clear-on-start, which beats a software W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack   <= 1'b0;
            wb_rdata <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            ie       <= 1'b0;
        end else begin
            wb_ack <= access;
            if (access) wb_rdata <= rd_mux;
            if (wr_ctrl) ie <= ctrl_wdata[CTRL_IE];

            if (set_done)                                done <= 1'b1;
            else if (clr_stat)                           done <= 1'b0;
            else if (wr_ctrl && ctrl_wdata[CTRL_DONE])   done <= 1'b0;

            if (set_err)                                 err <= 1'b1;
            else if (clr_stat)                           err <= 1'b0;
            else if (wr_ctrl && ctrl_wdata[CTRL_ERR])    err <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone memory-to-memory word copy engine: one read cycle, one gap, one write cycle, one gap per word.
// Holds the sequencing FSM, the SRC/DST/LEN counters and the single-word buffer.
module wb_copy_master
    import wb_copy_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        int_o
);

    state_t           state, state_nx;
    logic [31:0]      src, dst, word_buf;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             abort_req, abort_req_nx, abort_any;
    logic             start, abort, wr_src, wr_dst, wr_len;
    logic             set_done, set_err, clr_stat;
    logic             done, err, ie;
    logic             cyc_nx, we_nx;
    logic [31:0]      adr_nx, dat_nx;
    logic             wr_ok, rd_ok;
    logic             unused;

    assign unused    = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};
    assign busy      = is_busy(state);
    assign wbm_sel_o = 4'hF;
    assign int_o     = ie & (done | err);

    wb_copy_regs #(.LEN_W(LEN_W)) u_regs (
        .clk        (clk_i),
        .rst        (rst_i),
        .wb_cyc     (wbs_cyc_i),
        .wb_stb     (wbs_stb_i),
        .wb_we      (wbs_we_i),
        .wb_adr     (wbs_adr_i[3:2]),
        .ctrl_wdata (wbs_dat_i[5:0]),
        .wb_rdata   (wbs_dat_o),
        .wb_ack     (wbs_ack_o),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .busy       (busy),
        .set_done   (set_done),
        .set_err    (set_err),
        .clr_stat   (clr_stat),
        .wr_src     (wr_src),
        .wr_dst     (wr_dst),
        .wr_len     (wr_len),
        .start      (start),
        .abort      (abort),
        .done       (done),
        .err        (err),
        .ie         (ie)
    );

    // An abort is only honoured once the current bus cycle has finished.
    assign abort_any = abort_req | (abort & busy);
    assign rd_ok     = (state == RD) & wbm_ack_i & ~wbm_err_i;
    assign wr_ok     = (state == WR) & wbm_ack_i & ~wbm_err_i;
    assign set_done  = (state == FIN);
    assign clr_stat  = (state == IDLE) & start;

    always_comb begin
        state_nx = state;
        set_err  = 1'b0;
        case (state)
            IDLE:    if (start) state_nx = (len != '0) ? RD : FIN;
            RD: begin
                if (wbm_err_i) begin
                    state_nx = FIN;
                    set_err  = 1'b1;
                end else if (wbm_ack_i) begin
                    state_nx = abort_any ? FIN : RD_GAP;
                end
            end
            RD_GAP:  state_nx = abort_any ? FIN : WR;
            WR: begin
                if (wbm_err_i) begin
                    state_nx = FIN;
                    set_err  = 1'b1;
                end else if (wbm_ack_i) begin
                    state_nx = abort_any ? FIN : WR_GAP;
                end
            end
            WR_GAP:  state_nx = (abort_any || len == '0) ? FIN : RD;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        abort_req_nx = is_busy(state_nx) & abort_any;
        cyc_nx       = (state_nx == RD) || (state_nx == WR);
        we_nx        = (state_nx == WR);
        adr_nx       = '0;
        if (state_nx == RD) adr_nx = src;
        if (state_nx == WR) adr_nx = dst;
        dat_nx       = we_nx ? word_buf : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            abort_req <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            state     <= state_nx;
            abort_req <= abort_req_nx;
            wbm_cyc_o <= cyc_nx;
            wbm_stb_o <= cyc_nx;
            wbm_we_o  <= we_nx;
            wbm_adr_o <= adr_nx;
            wbm_dat_o <= dat_nx;
        end
    end

    // FSM counter updates take priority over slave writes, which are ignored while busy anyway.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src      <= '0;
            dst      <= '0;
            len      <= '0;
            word_buf <= '0;
        end else begin
            if (rd_ok) word_buf <= wbm_dat_i;
            if (wr_ok) begin
                src <= src + 32'd4;
                dst <= dst + 32'd4;
                len <= len - LEN_W'(1);
            end else if (!busy) begin
                if (wr_src) src <= wbs_dat_i;
                if (wr_dst) dst <= wbs_dat_i;
                if (wr_len) len <= wbs_dat_i[LEN_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed bench for wb_copy_master: a memory responder with wait states / error injection
// feeds a scoreboard of expected master transactions; register state is checked per scenario.
module tb_wb_copy_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [31:0] wbs_adr, wbs_dat;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;
    logic        int_o;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] mem[logic [31:0]];
    int          checks = 0;
    int          errors = 0;

    int wait_states = 0;
    int err_at_rd   = -1;
    bit sb_en       = 1'b1;
    bit gap_chk     = 1'b0;
    int rd_count    = 0;
    int wr_done     = 0;
    int wr_started  = 0;
    int cyc_starts  = 0;
    int idle_run    = 0;
    bit seen_acc    = 1'b0;
    bit prev_cyc    = 1'b0;
    int wcnt        = 0;

    always #5 clk = ~clk;

    wb_copy_master #(.LEN_W(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wbs_cyc_i (wbs_cyc),
        .wbs_stb_i (wbs_stb),
        .wbs_we_i  (wbs_we),
        .wbs_adr_i (wbs_adr),
        .wbs_dat_i (wbs_dat),
        .wbs_sel_i (wbs_sel),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .int_o     (int_o)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        txn_t t;
        t.we = we; t.adr = adr; t.dat = dat;
        exp_q.push_back(t);
    endtask

    // Expected read and write for one copied word.
    task automatic push_word(input logic [31:0] s, input logic [31:0] d);
        push(1'b0, s, pat(s));
        push(1'b1, d, pat(s));
    endtask

    // Memory responder, gap monitor and scoreboard; runs on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            wcnt      = 0;
            prev_cyc  = 1'b0;
        end else begin
            if (!gap_chk) seen_acc = 1'b0;
            if (wbm_cyc_o) begin
                if (!prev_cyc) begin
                    if (gap_chk && seen_acc) chk("gap_cycles", 32'(idle_run), 32'd1);
                    seen_acc = 1'b1;
                    idle_run = 0;
                    cyc_starts++;
                    if (wbm_we_o) wr_started++;
                end
            end else begin
                idle_run++;
            end
            prev_cyc = wbm_cyc_o;

            if (wbm_ack_i || wbm_err_i) begin
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
            end else if (wbm_cyc_o && wbm_stb_o) begin
                if (wcnt < wait_states) begin
                    wcnt++;
                end else begin
                    wcnt = 0;
                    if (!wbm_we_o && rd_count == err_at_rd) begin
                        wbm_err_i = 1'b1;
                        rd_count++;
                    end else begin
                        wbm_ack_i = 1'b1;
                        if (wbm_we_o) begin
                            mem[wbm_adr_o] = wbm_dat_o;
                            wr_done++;
                        end else begin
                            wbm_dat_i = pat(wbm_adr_o);
                            rd_count++;
                        end
                        if (sb_en) begin
                            if (exp_q.size() == 0) begin
                                chk("sb_unexpected_txn", wbm_adr_o, 32'hFFFF_FFFF);
                            end else begin
                                txn_t t;
                                t = exp_q.pop_front();
                                chk("sb_we", {31'b0, wbm_we_o}, {31'b0, t.we});
                                chk("sb_adr", wbm_adr_o, t.adr);
                                if (wbm_we_o) chk("sb_wdata", wbm_dat_o, t.dat);
                                chk("sb_sel", {28'b0, wbm_sel_o}, 32'hF);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic wbs_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              output logic [31:0] rdat);
        int n;
        logic got;
        @(negedge clk);
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we; wbs_adr = adr; wbs_dat = dat;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            got = wbs_ack_o;
            n++;
        end
        if (!got) chk("slave_ack_timeout", 32'd0, 32'd1);
        rdat = wbs_dat_o;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    endtask

    task automatic wbs_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] r;
        wbs_access(1'b1, adr, dat, r);
    endtask

    task automatic wbs_read(input logic [31:0] adr, output logic [31:0] r);
        wbs_access(1'b0, adr, 32'h0, r);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] r;
        int n;
        r = '0; n = 0;
        while (!r[2] && n < 100) begin
            wbs_read(32'hC, r);
            n++;
        end
        chk(tag, {31'b0, r[2]}, 32'd1);
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] adr, input logic [31:0] exp_v);
        logic [31:0] r;
        wbs_read(adr, r);
        chk(tag, r, exp_v);
    endtask

    initial begin
        int base, n;
        rst = 1'b1;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        wbs_adr = '0; wbs_dat = '0; wbs_sel = 4'hF;
        wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
        chk("rst_we", {31'b0, wbm_we_o}, 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_sel", {28'b0, wbm_sel_o}, 32'hF);
        chk("rst_int", {31'b0, int_o}, 32'd0);
        chk("rst_sack", {31'b0, wbs_ack_o}, 32'd0);
        chk_reg("rst_src", 32'h0, 32'h0);
        chk_reg("rst_dst", 32'h4, 32'h0);
        chk_reg("rst_len", 32'h8, 32'h0);
        chk_reg("rst_ctrl", 32'hC, 32'h0);

        // 1: three-word copy, zero wait states
        for (int i = 0; i < 3; i++) push_word(32'h100 + 32'(4 * i), 32'h200 + 32'(4 * i));
        wbs_write(32'h0, 32'h100);
        wbs_write(32'h4, 32'h200);
        wbs_write(32'h8, 32'd3);
        chk_reg("t1_src_rb", 32'h0, 32'h100);
        wbs_write(32'hC, 32'h1);
        wait_done("t1_done");
        chk_reg("t1_ctrl", 32'hC, 32'h4);
        chk_reg("t1_len", 32'h8, 32'h0);
        chk_reg("t1_src", 32'h0, 32'h10C);
        chk_reg("t1_dst", 32'h4, 32'h20C);
        chk("t1_mem_208", mem[32'h208], pat(32'h108));
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // 2: zero-length start with interrupt enabled
        base = cyc_starts;
        wbs_write(32'h8, 32'd0);
        wbs_write(32'hC, 32'h9);
        @(negedge clk);
        chk("t2_int_set", {31'b0, int_o}, 32'd1);
        chk_reg("t2_ctrl", 32'hC, 32'hC);
        chk("t2_no_cyc", 32'(cyc_starts - base), 32'd0);
        wbs_write(32'hC, 32'h4);
        chk("t2_int_clr", {31'b0, int_o}, 32'd0);

        // 3: three wait states, gap between accesses must be exactly one cycle
        wait_states = 3;
        gap_chk = 1'b1;
        base = cyc_starts;
        for (int i = 0; i < 2; i++) push_word(32'h300 + 32'(4 * i), 32'h380 + 32'(4 * i));
        wbs_write(32'h0, 32'h300);
        wbs_write(32'h4, 32'h380);
        wbs_write(32'h8, 32'd2);
        wbs_write(32'hC, 32'h1);
        wait_done("t3_done");
        gap_chk = 1'b0;
        chk("t3_cycles", 32'(cyc_starts - base), 32'd4);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: bus error on the second read of a four-word copy
        wait_states = 1;
        base = wr_done;
        err_at_rd = rd_count + 1;
        push_word(32'h400, 32'h480);
        wbs_write(32'h0, 32'h400);
        wbs_write(32'h4, 32'h480);
        wbs_write(32'h8, 32'd4);
        wbs_write(32'hC, 32'h1);
        wait_done("t4_done");
        err_at_rd = -1;
        chk_reg("t4_ctrl", 32'hC, 32'h14);
        chk_reg("t4_src", 32'h0, 32'h404);
        chk_reg("t4_len", 32'h8, 32'd3);
        chk("t4_writes", 32'(wr_done - base), 32'd1);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: abort during the second write; SRC writes while busy are ignored
        wait_states = 8;
        base = wr_started;
        for (int i = 0; i < 2; i++) push_word(32'h500 + 32'(4 * i), 32'h580 + 32'(4 * i));
        wbs_write(32'h0, 32'h500);
        wbs_write(32'h4, 32'h580);
        wbs_write(32'h8, 32'd5);
        wbs_write(32'hC, 32'h1);
        n = 0;
        while ((wr_started - base) < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5_second_write_seen", {31'b0, (n < 500)}, 32'd1);
        wbs_write(32'h0, 32'hDEAD_0000);
        wbs_write(32'hC, 32'h20);
        wait_done("t5_done");
        chk_reg("t5_ctrl", 32'hC, 32'h4);
        chk_reg("t5_len", 32'h8, 32'd3);
        chk_reg("t5_src", 32'h0, 32'h508);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // 6: reset in the middle of a write cycle
        sb_en = 1'b0;
        wait_states = 4;
        base = wr_started;
        wbs_write(32'h0, 32'h600);
        wbs_write(32'h4, 32'h680);
        wbs_write(32'h8, 32'd4);
        wbs_write(32'hC, 32'h9);
        n = 0;
        while ((wr_started - base) < 1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t6_write_seen", {31'b0, wbm_cyc_o & wbm_we_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk("t6_stb", {31'b0, wbm_stb_o}, 32'd0);
        chk("t6_we", {31'b0, wbm_we_o}, 32'd0);
        chk("t6_adr", wbm_adr_o, 32'd0);
        chk("t6_dat", wbm_dat_o, 32'd0);
        chk("t6_sel", {28'b0, wbm_sel_o}, 32'hF);
        chk("t6_int", {31'b0, int_o}, 32'd0);
        rst = 1'b0;
        chk_reg("t6_ctrl", 32'hC, 32'h0);
        chk_reg("t6_len", 32'h8, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
